my_add_sequencer: RTL
=====================

MY_ADD_SEQUENCER -- requirements
Module: my_add_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the clock, rst_n is the reset, and rst_n low resets the block.
REQ-002 Parameter: none; all widths are fixed at 8 bits.
REQ-003 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active low.
REQ-005 ena  input  1  design-powered indicator; always 1 and functionally ignored.
REQ-006 ui_in  input  8  operand data; at start, ui_in[3:0] is the operand count minus one.
REQ-007 uio_in  input  8  bit 0 start, bit 1 valid (operand strobe); bits 7:2 unused.
REQ-008 uo_out  output  8  result register.
REQ-009 uio_out  output  8  bit 4 busy, bit 5 done, bit 6 overflow, bit 7 ready; bits 3:0 are 0.
REQ-010 uio_oe  output  8  constant 0xF0.

Function
REQ-011 start and valid SHALL each pass through a 2-flop synchronizer followed by a rising-edge detector: edge = sync2 & ~prev.
REQ-012 A pin rising before clk edge e1 SHALL be acted on at edge e3; ui_in SHALL be sampled at that edge.
REQ-013 FSM states: IDLE, ACCUM, DONE.
REQ-014 IDLE + start edge -> ACCUM; cnt <= ui_in[3:0] (N = cnt+1, range 1..16); acc <= 0; ovf_sticky <= 0.
REQ-015 In IDLE, valid edges SHALL be ignored; if start and valid edges occur in the same cycle, start wins.
REQ-016 ACCUM + valid edge, cnt != 0: acc <= acc + ui_in (mod 256); ovf_sticky |= carry-out; cnt <= cnt - 1.
REQ-017 ACCUM + valid edge, cnt == 0: result_q <= acc + ui_in (mod 256); ovf_q <= ovf_sticky | carry-out; state -> DONE.
REQ-018 In ACCUM, start edges SHALL be ignored; there is no timeout.
REQ-019 DONE SHALL last exactly one cycle with done = 1, then go to IDLE unconditionally; start and valid edges in DONE are ignored.
REQ-020 uo_out = result_q and uio_out[6] = ovf_q; both SHALL hold until the next completion or reset, and SHALL be unchanged while a new run is in ACCUM.
REQ-021 ready = (state == IDLE); busy = (state == ACCUM); done = (state == DONE); all three are registered-state decodes.
REQ-022 A valid held high SHALL count as exactly one operand; a new operand requires valid to go low and high again.
REQ-023 The adder SHALL be a single shared 8-bit adder with carry-out; 8-bit wrap-around is legal and flagged only through overflow.

Reset
REQ-024 While rst_n is low: state = IDLE; acc, cnt, result_q, ovf_q, ovf_sticky and all synchronizer/edge flops = 0.
REQ-025 Outputs under reset: uo_out = 0x00, uio_out = 0x80, uio_oe = 0xF0.
REQ-026 Reset asserted mid-ACCUM SHALL abort the run with no done pulse; the first start edge after release SHALL begin a clean run.

Structure
REQ-027 A shared package SHALL hold the state enum, the uio bit-index constants (START=0, VALID=1, BUSY=4, DONE=5, OVF=6, READY=7) and the OE mask 0xF0.
REQ-028 One sub-module, sync_edge (2-flop synchronizer plus rising-edge pulse, async active-low reset), SHALL be instantiated once each for start and valid.
REQ-029 The adder, counter and FSM SHALL live in my_add_sequencer; all unused inputs SHALL be explicitly sunk.

Verification
REQ-030 Reset: rst_n low -> uo_out = 0x00, uio_out = 0x80, uio_oe = 0xF0; after release, no change without stimulus.
REQ-031 start with ui_in = 0x02; operands 0x10, 0x20, 0x30 -> uo_out = 0x60, overflow = 0, done high 1 cycle, ready returns to 1.
REQ-032 start with ui_in = 0x01; operands 0xF0, 0x20 -> uo_out = 0x10, overflow = 1.
REQ-033 start with ui_in = 0x0F; 16 operands of 0x01 -> uo_out = 0x10, overflow = 0; busy high throughout the run.
REQ-034 One operand 0x55 accepted, then rst_n pulsed -> reset values, no done pulse; next run with N = 1 and operand 0x07 -> uo_out = 0x07.
REQ-035 valid held high 20 cycles, plus a start edge during ACCUM -> counted as one operand, start ignored; run completes after the remaining strobes.

Source files
------------

// File: rtl/my_add_sequencer_pkg.sv
// ============================================================================
// Module   : my_add_sequencer_pkg
// Purpose  : Shared types and constants for the operand add sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package my_add_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int          c_uio_start = 0;
  localparam int          c_uio_valid = 1;
  localparam int          c_uio_busy  = 4;
  localparam int          c_uio_done  = 5;
  localparam int          c_uio_ovf   = 6;
  localparam int          c_uio_ready = 7;
  localparam logic [7:0]  c_oe_mask   = 8'hF0;

endpackage

`default_nettype wire

// File: rtl/my_add_sequencer_if.sv
// ============================================================================
// Module   : my_add_sequencer_if
// Purpose  : Pin bundle between the sequencer and its driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface my_add_sequencer_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

`default_nettype wire

// File: rtl/my_add_sequencer_sync_edge.sv
// ============================================================================
// Module   : sync_edge
// Purpose  : Two-flop synchronizer followed by a one-cycle rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_edge = r_sync2 & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/my_add_sequencer.sv
// ============================================================================
// Module   : my_add_sequencer
// Purpose  : Accumulates N strobed 8-bit operands and reports sum + overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_add_sequencer
  import my_add_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  my_add_sequencer_if.slave    bus
);

  logic       w_start_edge;
  logic       w_valid_edge;
  logic [8:0] w_sum;
  logic       w_unused;

  state_t     r_state,      w_state_nxt;
  logic [7:0] r_acc,        w_acc_nxt;
  logic [3:0] r_cnt,        w_cnt_nxt;
  logic [7:0] r_result,     w_result_nxt;
  logic       r_ovf,        w_ovf_nxt;
  logic       r_ovf_sticky, w_ovf_sticky_nxt;

  sync_edge u_start_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (bus.uio_in[c_uio_start]),
    .o_edge (w_start_edge)
  );

  sync_edge u_valid_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (bus.uio_in[c_uio_valid]),
    .o_edge (w_valid_edge)
  );

  // One adder serves both the running sum and the final result.
  assign w_sum = {1'b0, r_acc} + {1'b0, bus.ui_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_acc        <= 8'h00;
      r_cnt        <= 4'h0;
      r_result     <= 8'h00;
      r_ovf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_result     <= w_result_nxt;
      r_ovf        <= w_ovf_nxt;
      r_ovf_sticky <= w_ovf_sticky_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_cnt_nxt        = r_cnt;
    w_result_nxt     = r_result;
    w_ovf_nxt        = r_ovf;
    w_ovf_sticky_nxt = r_ovf_sticky;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt      = ST_ACCUM;
          w_cnt_nxt        = bus.ui_in[3:0];
          w_acc_nxt        = 8'h00;
          w_ovf_sticky_nxt = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (w_valid_edge) begin
          if (r_cnt != 4'h0) begin
            w_acc_nxt        = w_sum[7:0];
            w_ovf_sticky_nxt = r_ovf_sticky | w_sum[8];
            w_cnt_nxt        = r_cnt - 4'h1;
          end else begin
            w_result_nxt = w_sum[7:0];
            w_ovf_nxt    = r_ovf_sticky | w_sum[8];
            w_state_nxt  = ST_DONE;
          end
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.uio_out              = 8'h00;
    bus.uio_out[c_uio_busy]  = (r_state == ST_ACCUM);
    bus.uio_out[c_uio_done]  = (r_state == ST_DONE);
    bus.uio_out[c_uio_ovf]   = r_ovf;
    bus.uio_out[c_uio_ready] = (r_state == ST_IDLE);
  end

  assign bus.uo_out = r_result;
  assign bus.uio_oe = c_oe_mask;

  assign w_unused = &{1'b0, bus.ena, bus.uio_in[7:2]};

endmodule

`default_nettype wire
